dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_ram.sv | 37 +++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// The error-cause codes let a checker classify a failed access.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_W = 32;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    function automatic logic [1:0] classify(input logic misaligned, input logic out_of_range);
        return {out_of_range, misaligned};
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 word RAM with one write port and a registered read port.
// The read register doubles as the response data register, so it has its own clear.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts a MEM-stage request, stalls the
// pipeline for WAIT_CYCLES busy cycles, then commits/reads and pulses a response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              mem_stall,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              prot_err
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic              wr_reg;
    logic              resp_valid_reg;
    logic              resp_err_reg;
    logic              prot_err_reg;

    logic              req_any;
    logic              accept;
    logic              done_entry;
    logic [ADDR_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_wr;
    logic [1:0]        err_code;
    logic              legal;
    logic              ram_we;
    logic              ram_re;
    logic              ram_clr;

    assign req_any = req_read | req_write;
    assign accept  = (state_reg == IDLE) && req_any;

    // With zero wait states DONE is entered straight from IDLE, so the access
    // must be taken from the live request rather than the latched copy.
    assign acc_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
    assign acc_wr    = (state_reg == IDLE) ? req_write : wr_reg;

    assign err_code = classify(|acc_addr[1:0], (acc_addr >> 2) >= ADDR_W'(DEPTH));
    assign legal    = (err_code == ERR_NONE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_entry = 1'b0;
        mem_stall  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_any) begin
                    mem_stall = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = DONE;
                        done_entry = 1'b1;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                    done_entry = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A reset on the DONE-entry edge must cancel the write, hence rst_n gating.
    assign ram_we  = rst_n & done_entry & legal & acc_wr;
    assign ram_re  = rst_n & done_entry & legal & ~acc_wr;
    assign ram_clr = ~rst_n | (done_entry & ~ram_re);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wr_reg         <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            prot_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            resp_valid_reg <= done_entry;
            resp_err_reg   <= done_entry & ~legal;
            if (accept) begin
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                wr_reg    <= req_write;
                if (req_read && req_write) begin
                    prot_err_reg <= 1'b1;
                end
            end
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .clr   (ram_clr),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (resp_rdata)
    );

    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign prot_err   = prot_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven with
// directed and random accesses, checked against an array model of the RAM.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic        req_read   [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        mem_stall  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        prot_err   [2];

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;
    logic [31:0] model [2][DEPTH];
    bit          prot_model [2];
    int          waits_of [2] = '{2, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .ADDR_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_read(req_read[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .mem_stall(mem_stall[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .prot_err(prot_err[0]));

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_read(req_read[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .mem_stall(mem_stall[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .prot_err(prot_err[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] expected_code(input logic [31:0] a);
        logic [1:0] code;
        code = ERR_NONE;
        if (a[1:0] != 2'b00) code = code | ERR_MISALIGN;
        if ((a >> 2) >= 32'(DEPTH)) code = code | ERR_RANGE;
        return code;
    endfunction

    task automatic check_outputs_zero(input int d, input string tag);
        check({tag, ".stall"}, 32'(mem_stall[d]), 32'd0);
        check({tag, ".valid"}, 32'(resp_valid[d]), 32'd0);
        check({tag, ".rdata"}, resp_rdata[d], 32'd0);
        check({tag, ".err"}, 32'(resp_err[d]), 32'd0);
        check({tag, ".prot"}, 32'(prot_err[d]), 32'd0);
    endtask

    // One complete access through the pipeline handshake; returns the cycle of the response.
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input string tag, output int resp_cycle);
        bit          lg;
        bit          got;
        int          stalls;
        int          idx;
        logic [31:0] exp_rdata;
        lg        = (expected_code(a) == ERR_NONE);
        idx       = int'(a >> 2) & (DEPTH - 1);
        exp_rdata = (lg && !wr) ? model[d][idx] : 32'd0;
        if (lg && wr) model[d][idx] = wd;
        if (rd && wr) prot_model[d] = 1'b1;
        stalls = 0;
        got    = 1'b0;
        req_read[d]  = rd;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (mem_stall[d]) stalls++;
            step();
            if (resp_valid[d]) begin
                got = 1'b1;
                break;
            end
        end
        resp_cycle = cycle;
        check({tag, ".resp_seen"}, 32'(got), 32'd1);
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(waits_of[d] + 1));
        check({tag, ".done_stall"}, 32'(mem_stall[d]), 32'd0);
        check({tag, ".err"}, 32'(resp_err[d]), 32'(!lg));
        check({tag, ".rdata"}, resp_rdata[d], exp_rdata);
        check({tag, ".prot"}, 32'(prot_err[d]), 32'(prot_model[d]));
        $display("txn dut%0d %s rd=%0b wr=%0b addr=%h wdata=%h rdata=%h err=%0b stalls=%0d",
                 d, tag, rd, wr, a, wd, resp_rdata[d], resp_err[d], stalls);
        req_read[d]  = 1'b0;
        req_write[d] = 1'b0;
        step();
        check({tag, ".valid_clear"}, 32'(resp_valid[d]), 32'd0);
        check({tag, ".err_clear"}, 32'(resp_err[d]), 32'd0);
        check({tag, ".rdata_hold"}, resp_rdata[d], exp_rdata);
    endtask

    initial begin
        int          rc0;
        int          rc1;
        logic [31:0] a;
        logic [31:0] wd;
        bit          rd;
        bit          wr;
        int          k;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_read[d] = 1'b0; req_write[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; prot_model[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
        end
        repeat (3) step();
        check_outputs_zero(0, "reset0");
        check_outputs_zero(1, "reset1");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        step();

        // Preload every word so all later reads have a known expected value.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wd = (i == 0) ? 32'd5 : (i == 1) ? 32'd7 : (i == 9) ? 32'd0 : $urandom;
                access(d, 1'b0, 1'b1, 32'(i * 4), wd, "preload", rc0);
            end
        end

        access(0, 1'b0, 1'b1, 32'h10, 32'h0000_00AB, "wr_ab", rc0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd_ab", rc0);
        check("rd_ab.value", resp_rdata[0], 32'h0000_00AB);

        access(1, 1'b1, 1'b0, 32'h0, 32'h0, "b2b_rd0", rc0);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, "b2b_rd4", rc1);
        check("b2b.gap", 32'(rc1 - rc0), 32'd2);

        access(0, 1'b1, 1'b0, 32'h13, 32'h0, "misalign", rc0);
        access(0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, "range", rc0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd_ab_again", rc0);
        check("rd_ab_again.value", resp_rdata[0], 32'h0000_00AB);

        access(0, 1'b1, 1'b1, 32'h20, 32'h55, "both", rc0);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, "rd_55", rc0);
        check("rd_55.value", resp_rdata[0], 32'h55);

        // Reset lands on the edge that would have entered DONE.
        req_write[0] = 1'b1; req_read[0] = 1'b0;
        req_addr[0] = 32'h24; req_wdata[0] = 32'h99;
        step();
        step();
        check("rst_busy.stall", 32'(mem_stall[0]), 32'd1);
        rst_n[0] = 1'b0;
        req_write[0] = 1'b0;
        step();
        check_outputs_zero(0, "rst_busy");
        rst_n[0] = 1'b1;
        prot_model[0] = 1'b0;
        step();
        check("rst_busy.no_resp", 32'(resp_valid[0]), 32'd0);
        access(0, 1'b1, 1'b0, 32'h24, 32'h0, "rd_24", rc0);
        check("rd_24.value", resp_rdata[0], 32'h0);

        for (int n = 0; n < 60; n++) begin
            int d;
            d = n % 2;
            k = $urandom_range(0, 9);
            if (k == 0) begin
                a = 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'($urandom_range(1, 3));
            end else if (k == 1) begin
                a = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
            end else begin
                a = 32'(4 * $urandom_range(0, DEPTH - 1));
            end
            k  = $urandom_range(0, 9);
            rd = (k == 0) || (k > 4);
            wr = (k <= 4);
            wd = $urandom;
            access(d, rd, wr, a, wd, "rand", rc0);
        end

        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < 2; d++) begin
                check("idle.stall", 32'(mem_stall[d]), 32'd0);
                check("idle.valid", 32'(resp_valid[d]), 32'd0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
